vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640 (visible px), H_FP 24 (h front porch), H_PULSE 40 (hsync width), H_BP 128 (h back porch), V_ACTIVE 480 (visible lines), V_FP 9, V_PULSE 3, V_BP 28; derived BLACK_H=H_FP+H_PULSE+H_BP, BLACK_V=V_FP+V_PULSE+V_BP, H_TOTAL=BLACK_H+H_ACTIVE, V_TOTAL=BLACK_V+V_ACTIVE.
REQ-002 SHALL have ports:
clk  in  1  pixel clock, one pixel per cycle, rising edge.
rst  in  1  asynchronous active-high reset.
hsync  in  1  active-low horizontal sync, synchronous to clk.
vsync  in  1  active-low vertical sync, synchronous to clk.
x_px  out  10  recovered column, registered.
y_px  out  10  recovered row, registered.
activevideo  out  1  recovered visible-region flag, registered.
locked  out  1  timing lock flag, registered.
frame_start  out  1  one-cycle pulse on first visible pixel of a locked frame.
err  out  1  one-cycle pulse on timing mismatch.
REQ-003 SHALL use one clock; reset asynchronous and active-high.

Function
REQ-004 SHALL keep hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1) as the index of the sample currently on the inputs; hc wraps H_TOTAL-1 -> 0; vc increments when hc wraps, vc wraps V_TOTAL-1 -> 0.
REQ-005 SHALL register hsync/vsync into hs_d/vs_d; hfall = hs_d & ~hsync, vfall = vs_d & ~vsync.
REQ-006 SHALL implement states SEARCH, H_LOCK, VERIFY, LOCKED.
REQ-007 SEARCH: on hfall, load hc so the current sample is index H_FP (hc <= H_FP+1) and go H_LOCK; vfall ignored.
REQ-008 H_LOCK: h-error if hfall XOR (hc==H_FP); on vfall with hc==0, load vc so current sample is index V_FP, go VERIFY; vfall with hc!=0 is an error.
REQ-009 VERIFY: h-error rule as REQ-008; v-error if vfall XOR (vc==V_FP && hc==0); on correct vfall go LOCKED.
REQ-010 LOCKED: same h-error and v-error rules; stays LOCKED while no error.
REQ-011 Any error in H_LOCK/VERIFY/LOCKED: err=1 for exactly one cycle (next cycle), state -> SEARCH; an hfall causing the error is NOT reused for realignment.
REQ-012 h-error and v-error in the same cycle SHALL produce a single err pulse.
REQ-013 locked SHALL be 1 the cycle after the state register becomes LOCKED and 0 the cycle after it leaves.
REQ-014 One-cycle output latency: for sample with index (hc,vc), registered next cycle: activevideo = LOCKED && hc>=BLACK_H && vc>=BLACK_V; x_px = hc-BLACK_H, y_px = vc-BLACK_V when active, else both 0.
REQ-015 frame_start SHALL be 1 in the same cycle as activevideo=1 with x_px=0, y_px=0, else 0.
REQ-016 Subtraction results SHALL be 10 bits; with defaults x_px max 639, y_px max 479.
REQ-017 Counters SHALL keep running in all states; outside LOCKED their values do not affect outputs.

Reset
REQ-018 On rst: state SEARCH, hc=0, vc=0, hs_d=0, vs_d=0 (input low at release is not an edge); x_px=0, y_px=0, activevideo=0, locked=0, frame_start=0, err=0.
REQ-019 rst asserted mid-frame SHALL clear lock immediately; relock requires the full SEARCH->H_LOCK->VERIFY->LOCKED sequence.

Verification
REQ-020 Clean 832x520 default timing from reset -> locked=1 one cycle after the second vsync fall; err never asserted.
REQ-021 Locked, clean stream -> per cycle, outputs equal the generator's (hc-192, vc-40) in visible region, 0 elsewhere; frame_start once per 432640 cycles at x=0,y=0.
REQ-022 Locked, one hsync fall delayed by 1 cycle -> err pulse at hc index 24, locked falls next cycle, relock within 2 frames.
REQ-023 Locked, one vsync pulse suppressed -> err pulse one cycle after the expected index (hc=0,vc=9); locked=0.
REQ-024 rst pulse at frame mid-point -> all outputs 0 next edge; locked returns after second subsequent vsync fall.
REQ-025 hsync/vsync held low through reset release -> no edge detected, state remains SEARCH until the first true fall.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and a visible-region flag from a bare hsync/vsync pair.
// A small lock FSM aligns free-running counters to the sync edges and drops lock on any timing slip.
module vga_sync_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 24,
  parameter int H_PULSE  = 40,
  parameter int H_BP     = 128,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 9,
  parameter int V_PULSE  = 3,
  parameter int V_BP     = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic       activevideo,
  output logic       locked,
  output logic       frame_start,
  output logic       err
);

  localparam int BLACK_H = H_FP + H_PULSE + H_BP;
  localparam int BLACK_V = V_FP + V_PULSE + V_BP;
  localparam int H_TOTAL = BLACK_H + H_ACTIVE;
  localparam int V_TOTAL = BLACK_V + V_ACTIVE;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  typedef enum logic [1:0] {SEARCH, H_LOCK, VERIFY, LOCKED} state_t;

  state_t        state;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          hs_d;
  logic          vs_d;

  logic          hfall;
  logic          vfall;
  logic          h_at_fp;
  logic          v_at_fp;
  logic          h_err;
  logic          v_err;
  logic          any_err;
  logic [HW-1:0] hc_inc;
  logic [VW-1:0] vc_inc;
  logic          active_now;
  logic [9:0]    x_next;
  logic [9:0]    y_next;
  logic          fs_next;

  // Edge detection and the expected-edge positions, all for the sample now on the inputs.
  always_comb begin
    hfall   = hs_d & ~hsync;
    vfall   = vs_d & ~vsync;
    h_at_fp = (hc == HW'(H_FP));
    v_at_fp = (vc == VW'(V_FP)) && (hc == '0);
    h_err   = hfall ^ h_at_fp;
    v_err   = vfall ^ v_at_fp;
  end

  // Before vertical alignment only the position of the vsync edge within the line is checked.
  always_comb begin
    any_err = 1'b0;
    case (state)
      H_LOCK:         any_err = h_err | (vfall & (hc != '0));
      VERIFY, LOCKED: any_err = h_err | v_err;
      default:        any_err = 1'b0;
    endcase
  end

  always_comb begin
    hc_inc = hc + HW'(1);
    vc_inc = vc;
    if (hc == HW'(H_TOTAL - 1)) begin
      hc_inc = '0;
      vc_inc = (vc == VW'(V_TOTAL - 1)) ? '0 : vc + VW'(1);
    end
  end

  always_comb begin
    active_now = (state == LOCKED) && (hc >= HW'(BLACK_H)) && (vc >= VW'(BLACK_V));
    x_next     = '0;
    y_next     = '0;
    if (active_now) begin
      x_next = 10'(hc - HW'(BLACK_H));
      y_next = 10'(vc - VW'(BLACK_V));
    end
    fs_next = active_now && (hc == HW'(BLACK_H)) && (vc == VW'(BLACK_V));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      hc          <= '0;
      vc          <= '0;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      x_px        <= '0;
      y_px        <= '0;
      activevideo <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
    end else begin
      hs_d        <= hsync;
      vs_d        <= vsync;
      hc          <= hc_inc;
      vc          <= vc_inc;
      err         <= any_err;
      locked      <= (state == LOCKED);
      activevideo <= active_now;
      x_px        <= x_next;
      y_px        <= y_next;
      frame_start <= fs_next;
      case (state)
        SEARCH: begin
          // The current sample is the front-porch end, so the next one is H_FP+1.
          if (hfall) begin
            hc    <= HW'(H_FP + 1);
            state <= H_LOCK;
          end
        end
        H_LOCK: begin
          if (any_err) begin
            state <= SEARCH;
          end else if (vfall) begin
            vc    <= VW'(V_FP);
            state <= VERIFY;
          end
        end
        VERIFY: begin
          if (any_err) state <= SEARCH;
          else if (vfall) state <= LOCKED;
        end
        LOCKED: begin
          if (any_err) state <= SEARCH;
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 16x8 timing so whole frames stay short.
module tb_vga_sync_decoder;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_PULSE  = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_PULSE  = 2;
  localparam int V_BP     = 1;
  localparam int BH       = 8;
  localparam int BV       = 4;
  localparam int HT       = 16;
  localparam int VT       = 8;
  localparam int FRAME    = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [9:0] x_px;
  logic [9:0] y_px;
  logic       activevideo;
  logic       locked;
  logic       frame_start;
  logic       err;

  int checks = 0;
  int errors = 0;
  int gh = 0, gv = 0, gf = 0;
  int ph = 0, pv = 0, pf = 0;
  int err_cnt = 0;
  int fs_cnt = 0;
  int tgt = 0;
  bit inj_hdelay = 0, inj_vsupp = 0, inj_vspur = 0;

  vga_sync_decoder #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_PULSE(H_PULSE), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_PULSE(V_PULSE), .V_BP(V_BP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hsync(hsync),
    .vsync(vsync),
    .x_px(x_px),
    .y_px(y_px),
    .activevideo(activevideo),
    .locked(locked),
    .frame_start(frame_start),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Nominal generator waveform at (gh,gv) with optional fault injection.
  task automatic drive();
    logic hs;
    logic vs;
    hs = !(gh >= H_FP && gh < H_FP + H_PULSE);
    vs = !(gv >= V_FP && gv < V_FP + V_PULSE);
    if (inj_hdelay && gh == H_FP) hs = 1'b1;
    if (inj_vsupp) vs = 1'b1;
    if (inj_vspur && gh == H_FP) vs = 1'b0;
    hsync = hs;
    vsync = vs;
  endtask

  // After each step the DUT outputs describe sample (pf,ph,pv).
  task automatic step();
    @(posedge clk);
    #1;
    ph = gh;
    pv = gv;
    pf = gf;
    if (err === 1'b1) err_cnt++;
    gh++;
    if (gh == HT) begin
      gh = 0;
      gv++;
      if (gv == VT) begin
        gv = 0;
        gf++;
      end
    end
    drive();
  endtask

  task automatic run_to(input int f, input int h, input int v);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(pf == f && ph == h && pv == v) && n < 2000);
    check("run_to_reached", (pf == f && ph == h && pv == v), 1);
  endtask

  task automatic wait_locked(input int budget);
    int n;
    n = 0;
    while (locked !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("relock", locked, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x"}, x_px, 0);
    check({tag, "_y"}, y_px, 0);
    check({tag, "_act"}, activevideo, 0);
    check({tag, "_lock"}, locked, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    drive();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Clean lock from reset: VERIFY after the first vsync fall, LOCKED after the second.
    run_to(1, 0, 1);
    check("lock_before", locked, 0);
    step();
    check("lock_after", locked, 1);
    check("startup_err", err_cnt, 0);

    // One full locked frame compared pixel by pixel.
    run_to(1, 15, 7);
    fs_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      check("frame_act", activevideo, (ph >= BH && pv >= BV));
      check("frame_x", x_px, (ph >= BH && pv >= BV) ? ph - BH : 0);
      check("frame_y", y_px, (ph >= BH && pv >= BV) ? pv - BV : 0);
      check("frame_fs", frame_start, (ph == BH && pv == BV));
      if (frame_start === 1'b1) fs_cnt++;
    end
    check("frame_fs_count", fs_cnt, 1);
    check("frame_err", err_cnt, 0);

    // Delayed hsync fall on line 5.
    run_to(3, 0, 5);
    inj_hdelay = 1;
    run_to(3, 2, 5);
    check("hdel_err", err, 1);
    check("hdel_lock_hold", locked, 1);
    inj_hdelay = 0;
    step();
    check("hdel_err_end", err, 0);
    check("hdel_lock_drop", locked, 0);
    check("hdel_act", activevideo, 0);
    wait_locked(3 * FRAME);

    // Suppressed vsync pulse.
    tgt = pf + 1;
    run_to(tgt, 0, 0);
    inj_vsupp = 1;
    run_to(tgt, 0, 1);
    check("vsup_err", err, 1);
    check("vsup_lock_hold", locked, 1);
    step();
    check("vsup_err_end", err, 0);
    check("vsup_lock_drop", locked, 0);
    run_to(tgt, 0, 4);
    inj_vsupp = 0;
    wait_locked(3 * FRAME);

    // Horizontal and vertical errors on the same sample give one pulse.
    tgt = pf + 1;
    run_to(tgt, 0, 5);
    err_cnt = 0;
    inj_hdelay = 1;
    inj_vspur = 1;
    run_to(tgt, 2, 5);
    check("dual_err", err, 1);
    inj_hdelay = 0;
    inj_vspur = 0;
    step();
    check("dual_err_end", err, 0);
    check("dual_err_count", err_cnt, 1);
    wait_locked(3 * FRAME);

    // Reset in the middle of a locked frame.
    tgt = pf + 1;
    run_to(tgt, 8, 4);
    check("mid_act", activevideo, 1);
    check("mid_x", x_px, 0);
    check("mid_y", y_px, 0);
    check("mid_fs", frame_start, 1);
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    step();
    check_zero("rst_edge");
    rst = 1'b0;
    err_cnt = 0;
    run_to(tgt + 2, 0, 1);
    check("rst_relock_before", locked, 0);
    step();
    check("rst_relock_after", locked, 1);
    check("rst_relock_err", err_cnt, 0);

    // Syncs held low through reset release must not look like edges.
    rst = 1'b1;
    hsync = 1'b0;
    vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("low_err", err, 0);
      check("low_lock", locked, 0);
    end
    gh = 0;
    gv = 0;
    gf = 0;
    pf = -1;
    err_cnt = 0;
    drive();
    run_to(1, 0, 1);
    check("low_lock_before", locked, 0);
    step();
    check("low_lock_after", locked, 1);
    check("low_err_count", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
